// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, instr} pairs.
// Handshake flags come only from registered state, so there is no ready/valid combinational path.
module inst_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_instr,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [DATA_WIDTH-1:0]     out_instr,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc_d    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_instr_d [DEPTH];
  logic                  push;
  logic                  pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_pc    = mem_pc_q[head_q];
  assign out_instr = mem_instr_q[head_q];
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    // A redirect discards the whole queue; same-cycle push/pop are dropped with it.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_pc_d[tail_q]    = in_pc;
        mem_instr_d[tail_q] = in_instr;
        tail_d              = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, a latency sequence, then random traffic
// checked against a queue-based reference model.
module tb_inst_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_pc, in_instr, out_pc, out_instr;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  inst_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, flush, iv, ordy;
    logic [DW-1:0] pc, instr;
    int            e_cnt;
    logic          e_ov, e_ir, chk;
    logic [DW-1:0] e_pc, e_instr;
  } vec_t;

  vec_t vq[$];

  typedef struct {
    logic [DW-1:0] pc, instr;
  } ent_t;

  ent_t model[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void v(input logic r, input logic f, input logic iv, input logic [DW-1:0] pc,
                            input logic [DW-1:0] ins, input logic ordy, input int ec,
                            input logic eov, input logic eir, input logic c,
                            input logic [DW-1:0] epc, input logic [DW-1:0] eins);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.pc = pc; t.instr = ins; t.ordy = ordy;
    t.e_cnt = ec; t.e_ov = eov; t.e_ir = eir; t.chk = c; t.e_pc = epc; t.e_instr = eins;
    vq.push_back(t);
  endfunction

  task automatic drive(input logic r, input logic f, input logic iv, input logic [DW-1:0] pc,
                       input logic [DW-1:0] ins, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    //  rst f  iv pc     instr  ordy cnt ov ir chk pc     instr
    v(1, 0, 0, 'h0,   'h0,   0, 0, 0, 1, 1, 'h0,   'h0);   // reset
    v(0, 0, 1, 'h0,   'h11,  0, 1, 1, 1, 1, 'h0,   'h11);  // fill
    v(0, 0, 1, 'h4,   'h22,  0, 2, 1, 1, 1, 'h0,   'h11);
    v(0, 0, 1, 'h8,   'h33,  0, 3, 1, 1, 1, 'h0,   'h11);
    v(0, 0, 1, 'hC,   'h44,  0, 4, 1, 0, 1, 'h0,   'h11);
    v(0, 0, 1, 'h10,  'h77,  0, 4, 1, 0, 1, 'h0,   'h11);  // fifth push rejected
    v(0, 0, 0, 'h0,   'h0,   1, 3, 1, 1, 1, 'h4,   'h22);  // pop 2
    v(0, 0, 0, 'h0,   'h0,   1, 2, 1, 1, 1, 'h8,   'h33);
    v(0, 0, 1, 'h10,  'h55,  0, 3, 1, 1, 1, 'h8,   'h33);  // wrap pushes
    v(0, 0, 1, 'h14,  'h66,  0, 4, 1, 0, 1, 'h8,   'h33);
    v(0, 0, 1, 'h18,  'h88,  1, 3, 1, 1, 1, 'hC,   'h44);  // push+pop when full: pop only
    v(0, 0, 0, 'h0,   'h0,   1, 2, 1, 1, 1, 'h10,  'h55);
    v(0, 0, 1, 'h18,  'h99,  1, 2, 1, 1, 1, 'h14,  'h66);  // push+pop at count 2
    v(0, 0, 0, 'h0,   'h0,   1, 1, 1, 1, 1, 'h18,  'h99);
    v(0, 0, 0, 'h0,   'h0,   1, 0, 0, 1, 0, 'h0,   'h0);
    v(0, 0, 1, 'h40,  'hAA,  0, 1, 1, 1, 1, 'h40,  'hAA);  // push into empty
    v(0, 0, 1, 'h44,  'hBB,  0, 2, 1, 1, 1, 'h40,  'hAA);
    v(0, 0, 1, 'h48,  'hCC,  0, 3, 1, 1, 1, 'h40,  'hAA);
    v(0, 1, 1, 'h4C,  'hDD,  1, 0, 0, 1, 0, 'h0,   'h0);   // flush wins over push/pop
    v(0, 0, 1, 'h100, 'hEE,  0, 1, 1, 1, 1, 'h100, 'hEE);
    v(0, 0, 1, 'h104, 'hFF,  0, 2, 1, 1, 1, 'h100, 'hEE);
    v(1, 1, 1, 'h108, 'h123, 0, 0, 0, 1, 1, 'h0,   'h0);   // reset beats push and flush

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].flush, vq[i].iv, vq[i].pc, vq[i].instr, vq[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vq[i].e_cnt));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vq[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vq[i].e_ir));
      if (vq[i].chk) begin
        chk($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vq[i].e_pc));
        chk($sformatf("vec%0d_out_instr", i), 64'(out_instr), 64'(vq[i].e_instr));
      end
    end

    // Latency from an empty queue: nothing visible during the push cycle.
    drive(1'b0, 1'b0, 1'b1, 'h200, 'h321, 1'b0);
    @(negedge clk);
    chk("lat_push_cycle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("lat_next_out_valid", 64'(out_valid), 64'd1);
    chk("lat_next_out_pc", 64'(out_pc), 64'h200);
    chk("lat_next_out_instr", 64'(out_instr), 64'h321);

    // Random traffic against the model; start from a clean reset.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    model.delete();
    for (int c = 0; c < 600; c++) begin
      logic r, f, iv, ordy, do_push, do_pop;
      logic [DW-1:0] pc, ins;
      ent_t e;
      r    = ($urandom_range(0, 79) == 0);
      f    = ($urandom_range(0, 29) == 0);
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 1) == 1);
      pc   = $urandom;
      ins  = $urandom;
      drive(r, f, iv, pc, ins, ordy);
      do_push = iv && (model.size() != DEPTH);
      do_pop  = ordy && (model.size() != 0);
      if (r || f) begin
        model.delete();
      end else begin
        if (do_pop) void'(model.pop_front());
        if (do_push) begin
          e.pc = pc; e.instr = ins;
          model.push_back(e);
        end
      end
      @(posedge clk); #1;
      chk("rnd_count", 64'(count), 64'(model.size()));
      chk("rnd_out_valid", 64'(out_valid), 64'(model.size() != 0));
      chk("rnd_in_ready", 64'(in_ready), 64'(model.size() != DEPTH));
      if (model.size() != 0) begin
        chk("rnd_out_pc", 64'(out_pc), 64'(model[0].pc));
        chk("rnd_out_instr", 64'(out_instr), 64'(model[0].instr));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the PC and instruction words.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entry count; legal values are powers of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-006 The block SHALL have port in_pc, input, DATA_WIDTH bits: PC of the presented instruction.
REQ-007 The block SHALL have port in_instr, input, DATA_WIDTH bits: instruction word read at in_pc.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the queue accepts a push this cycle; the fetch stage uses its inverse as stall.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-010 The block SHALL have port out_pc, output, DATA_WIDTH bits: PC of the head entry.
REQ-011 The block SHALL have port out_instr, output, DATA_WIDTH bits: instruction of the head entry.
REQ-012 The block SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-013 The block SHALL have port flush, input, 1 bit: discard all entries on a branch/jump redirect.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of valid entries.

Function
REQ-015 The block SHALL perform a push when in_valid and in_ready are both 1 at a rising edge, writing {in_pc, in_instr} at the tail and advancing the tail pointer.
REQ-016 The block SHALL perform a pop when out_valid and out_ready are both 1 at a rising edge, advancing the head pointer.
REQ-017 The block SHALL wrap the head and tail pointers modulo DEPTH (log2(DEPTH) bits, natural rollover).
REQ-018 The block SHALL drive in_ready = (count != DEPTH) purely from registered state, with no combinational path from out_ready; a full queue therefore rejects a push even when a pop occurs in the same cycle.
REQ-019 The block SHALL drive out_valid = (count != 0) purely from registered state, with no bypass from input to output; push-to-out_valid latency is 1 cycle.
REQ-020 The block SHALL drive out_pc/out_instr from the head entry storage; their values are don't-care while out_valid=0.
REQ-021 The block SHALL update count as: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (legal when 0 < count < DEPTH) or on neither.
REQ-022 When flush=1, the block SHALL set head, tail and count to 0 at that edge, ignoring any push or pop in the same cycle; flush has priority over everything except rst.
REQ-023 The block SHALL present entries in FIFO order with pc/instr pairing preserved, and SHALL never drop or duplicate an entry except by flush or rst.
REQ-024 The block SHALL leave storage unchanged when in_valid=1 and in_ready=0.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL clear head, tail, count and all storage entries to 0, so that out_valid=0, in_ready=1, out_pc=0, out_instr=0 and count=0; rst overrides flush, push and pop.
REQ-026 Reset asserted mid-operation SHALL discard all entries with no partial commit of a same-cycle push.

Verification
REQ-027 Fill: after rst, push 0x0/0x11, 0x4/0x22, 0x8/0x33, 0xC/0x44 with out_ready=0 -> count=4, in_ready=0, out_pc=0x0; a fifth push of 0x10 is not stored.
REQ-028 Drain/wrap: from full, pop 2, push 0x10/0x55 and 0x14/0x66, pop 4 -> sequence 0x8, 0xC, 0x10, 0x14 with matching instructions; final count=0, out_valid=0.
REQ-029 Simultaneous push+pop at count=2 -> count stays 2, FIFO order preserved; push+pop at count=4 -> pop only, count=3.
REQ-030 Empty latency: push 0x40/0xAA into an empty queue -> out_valid=0 in the push cycle, then out_valid=1 with out_pc=0x40 one cycle later.
REQ-031 Flush: with count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; a subsequent push of 0x100 appears at the head.
REQ-032 Reset mid-stream: with count=2, assert rst together with push and flush -> all outputs at reset values next cycle.
